bus_arbiter: RTL

- Shares one single-ported external bus between two requesters: instruction fetch (IF) and the MEMORY-stage data port.
- Sits between pc_reg/if_id, the mem stage and the system bus.
- Sequences each access through a request/ack handshake and raises per-requester stall requests toward ctrl.
- Data accesses win arbitration over fetches.

---
 rtl/bus_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-way arbiter sharing one single-ported system bus between instruction fetch
// and the MEM-stage data port; data accesses take priority over fetches.
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stallreq_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i
);

  typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IDONE, DDONE} state_t;

  state_t state, state_nxt;
  logic   discard;
  logic   flush_seen;
  logic   grant_mem;
  logic   grant_if;
  logic   unused_stall;

  // Only the IF and MEM stall bits matter to this block.
  assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  // A flush anywhere in the fetch cycle, including the ack cycle, drops its result.
  assign flush_seen = discard | flush_i;
  assign grant_mem  = (state == IDLE) & mem_req_i;
  assign grant_if   = (state == IDLE) & ~mem_req_i & if_req_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_req_i)                 state_nxt = DBUSY;
        else if (if_req_i && !flush_i) state_nxt = IBUSY;
      end
      IBUSY:   if (bus_ack_i) state_nxt = flush_seen ? IDLE : IDONE;
      DBUSY:   if (bus_ack_i) state_nxt = DDONE;
      IDONE:   if (!stall_i[1] || flush_i) state_nxt = IDLE;
      DDONE:   if (!stall_i[4]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_stallreq_o  = 1'b0;
    mem_stallreq_o = 1'b0;
    if (!rst) begin
      if_stallreq_o  = if_req_i  & (state != IDONE);
      mem_stallreq_o = mem_req_i & (state != DDONE);
    end
  end

  // Bus request registers are loaded only on a grant and frozen until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= 4'b0000;
      bus_wdata_o <= '0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
      discard     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          discard <= 1'b0;
          if (grant_mem) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we_i;
            bus_addr_o  <= mem_addr_i;
            bus_sel_o   <= mem_sel_i;
            bus_wdata_o <= mem_wdata_i;
          end else if (grant_if) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= if_addr_i;
            bus_sel_o   <= 4'b1111;
            bus_wdata_o <= mem_wdata_i;
          end
        end
        IBUSY: begin
          if (flush_i) discard <= 1'b1;
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            if (!flush_seen) if_rdata_o <= bus_rdata_i;
          end
        end
        DBUSY: begin
          if (bus_ack_i) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            mem_rdata_o <= bus_we_o ? '0 : bus_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
